control_segmentacion: RTL and testbench
=======================================

Name: control_segmentacion

Overview:
Hazard and sequencing controller for the 5-stage JOF32 pipeline. It drives enable, flush and bubble controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also computes the ALU operand forwarding selects and stalls the whole pipeline while the data memory has a transaction outstanding, with a watchdog. It sits beside the datapath and is the only source of pipeline-register enables and flushes.

Parameters:
TIMEOUT, 15, max cycles in ESPERA_MEM before abort (1..255)
R0_FIJO, 1, 1: register 0 is hardwired zero, never forwarded and never a hazard source
ANCHO_CNT, 16, width of stall performance counter

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
id_rs1  in  4  ID-stage source register A
id_rs2  in  4  ID-stage source register B
id_usa_rs1  in  1  ID instruction reads rs1
id_usa_rs2  in  1  ID instruction reads rs2
ex_rs1  in  4  EX-stage source A (forwarding)
ex_rs2  in  4  EX-stage source B (forwarding)
ex_dir_wb  in  4  EX-stage destination
ex_reg_wr  in  1  EX instruction writes a register
ex_es_load  in  1  EX instruction is a load
mem_dir_wb  in  4  MEM-stage destination
mem_reg_wr  in  1  MEM writes a register
wb_dir_wb  in  4  WB-stage destination
wb_reg_wr  in  1  WB writes a register
ex_salto_tomado  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage issues data-memory access
mem_ack  in  1  data memory completes access
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_en  out  1  EX/MEM load enable
mem_wb_burbuja  out  1  MEM/WB loads bubble (reg_wr=0)
fwd_a  out  2  ALU operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  ALU operand B select, same encoding
mem_timeout  out  1  sticky: a memory access aborted by watchdog
cnt_stall  out  ANCHO_CNT  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0 at posedge): state RUN, watchdog=0, mem_timeout=0, cnt_stall=0. While rst_n=0: enables=1, flushes/burbuja=0, fwd=00.
- FSM states: RUN, ESPERA_MEM. Outputs are a combinational function of state and inputs.
- Match(r,d,w) = w && r==d && !(R0_FIJO && d==0).
- Forwarding, every cycle: fwd_a=01 if Match(ex_rs1,mem_dir_wb,mem_reg_wr), else 10 if Match(ex_rs1,wb_dir_wb,wb_reg_wr), else 00. MEM has priority over WB. fwd_b is identical using ex_rs2.
- Load-use: lu = ex_es_load && ((id_usa_rs1 && Match(id_rs1,ex_dir_wb,ex_reg_wr)) || (id_usa_rs2 && Match(id_rs2,ex_dir_wb,ex_reg_wr))).
- Memory wait: mw = mem_req && !mem_ack.
- Priority, RUN state:
  1. mw: pc_en, if_id_en, id_ex_en and ex_mem_en all 0; mem_wb_burbuja=1; next state ESPERA_MEM; watchdog=1.
  2. else ex_salto_tomado: if_id_flush=1, id_ex_flush=1; pc_en=1 (target loads). Overrides lu.
  3. else lu: pc_en=0, if_id_en=0, id_ex_flush=1. The stall lasts exactly 1 cycle because the load then advances out of EX.
  4. else all enables 1.
- A req and ack in the same cycle causes no stall.
- ESPERA_MEM:
  - Freeze outputs as in case 1.
  - mem_ack=1: return to RUN. This cycle ex_mem_en=1 and mem_wb_burbuja=0, so the result enters MEM/WB. Front stages apply RUN priorities 2–4 the same cycle.
  - mem_ack=0 and watchdog==TIMEOUT: set mem_timeout=1, return to RUN with the access abandoned. MEM/WB gets a bubble.
  - Otherwise: watchdog += 1.
- A taken branch during ESPERA_MEM stays held in frozen EX and is acted on after resume. Flush is never issued while frozen.
- cnt_stall increments on every cycle with pc_en=0 and saturates at all-ones.
- A reset mid-wait returns to RUN with watchdog cleared. Nothing is replayed.

Test Plan:
- Load r3 in EX, ID reads r3 via rs2 -> exactly 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; cnt_stall=1.
- mem_dir_wb=5 and wb_dir_wb=5, both reg_wr=1, ex_rs1=5 -> fwd_a=01. With mem_reg_wr=0 -> fwd_a=10. With all dests 0 and R0_FIJO=1 -> fwd_a=00.
- Taken branch coinciding with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1 for 1 cycle; no stall.
- mem_req held, ack after 3 cycles -> 3 cycles with all enables 0 and mem_wb_burbuja=1; ack cycle ex_mem_en=1, burbuja=0; cnt_stall=3.
- mem_req with no ack, TIMEOUT=4 -> mem_timeout=1 after the watchdog expires; FSM back in RUN; mem_timeout stays set until rst_n=0.
- rst_n=0 in ESPERA_MEM -> next posedge state RUN, enables=1, cnt_stall=0, mem_timeout=0.

Source files
------------

// File: rtl/control_segmentacion_if.sv
// Bundle between the JOF32 datapath and its hazard controller: stage register/destination
// info and the data-memory handshake go in, pipeline enables/flushes and forwarding selects come out.
interface control_segmentacion_if #(
  parameter int ANCHO_CNT = 16
) ();

  logic [3:0]           id_rs1;
  logic [3:0]           id_rs2;
  logic                 id_usa_rs1;
  logic                 id_usa_rs2;
  logic [3:0]           ex_rs1;
  logic [3:0]           ex_rs2;
  logic [3:0]           ex_dir_wb;
  logic                 ex_reg_wr;
  logic                 ex_es_load;
  logic [3:0]           mem_dir_wb;
  logic                 mem_reg_wr;
  logic [3:0]           wb_dir_wb;
  logic                 wb_reg_wr;
  logic                 ex_salto_tomado;
  logic                 mem_req;
  logic                 mem_ack;

  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_en;
  logic                 id_ex_flush;
  logic                 ex_mem_en;
  logic                 mem_wb_burbuja;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 mem_timeout;
  logic [ANCHO_CNT-1:0] cnt_stall;

  // Datapath side: reports stage contents, obeys the controls.
  modport master (
    output id_rs1, id_rs2, id_usa_rs1, id_usa_rs2, ex_rs1, ex_rs2, ex_dir_wb, ex_reg_wr,
           ex_es_load, mem_dir_wb, mem_reg_wr, wb_dir_wb, wb_reg_wr, ex_salto_tomado,
           mem_req, mem_ack,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_burbuja,
           fwd_a, fwd_b, mem_timeout, cnt_stall
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_usa_rs1, id_usa_rs2, ex_rs1, ex_rs2, ex_dir_wb, ex_reg_wr,
           ex_es_load, mem_dir_wb, mem_reg_wr, wb_dir_wb, wb_reg_wr, ex_salto_tomado,
           mem_req, mem_ack,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_burbuja,
           fwd_a, fwd_b, mem_timeout, cnt_stall
  );

endinterface

// File: rtl/control_segmentacion.sv
// Hazard and sequencing controller for the JOF32 5-stage pipeline: load-use stalls, branch
// flushes, ALU forwarding selects and a watchdog-guarded freeze while data memory is busy.
module control_segmentacion #(
  parameter int TIMEOUT   = 15,
  parameter int R0_FIJO   = 1,
  parameter int ANCHO_CNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  control_segmentacion_if.slave pipe
);

  typedef enum logic {RUN, ESPERA_MEM} estado_e;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  estado_e              state_q, state_d;
  logic [7:0]           watchdog_q, watchdog_d;
  logic                 memTimeout_q, memTimeout_d;
  logic [ANCHO_CNT-1:0] cntStall_q, cntStall_d;
  logic                 loadUse;
  logic                 memWait;
  logic                 frozen;

  function automatic logic match(input logic [3:0] r, input logic [3:0] d, input logic w);
    return w && (r == d) && !((R0_FIJO != 0) && (d == 4'd0));
  endfunction

  always_comb begin
    loadUse = pipe.ex_es_load &&
              ((pipe.id_usa_rs1 && match(pipe.id_rs1, pipe.ex_dir_wb, pipe.ex_reg_wr)) ||
               (pipe.id_usa_rs2 && match(pipe.id_rs2, pipe.ex_dir_wb, pipe.ex_reg_wr)));
    memWait = pipe.mem_req && !pipe.mem_ack;
    // In the wait state only the ack matters; the request line may already have dropped.
    frozen  = (state_q == RUN) ? memWait : !pipe.mem_ack;
  end

  always_comb begin
    pipe.fwd_a = 2'b00;
    pipe.fwd_b = 2'b00;
    if (rst_n) begin
      if (match(pipe.ex_rs1, pipe.mem_dir_wb, pipe.mem_reg_wr))     pipe.fwd_a = 2'b01;
      else if (match(pipe.ex_rs1, pipe.wb_dir_wb, pipe.wb_reg_wr))  pipe.fwd_a = 2'b10;
      if (match(pipe.ex_rs2, pipe.mem_dir_wb, pipe.mem_reg_wr))     pipe.fwd_b = 2'b01;
      else if (match(pipe.ex_rs2, pipe.wb_dir_wb, pipe.wb_reg_wr))  pipe.fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      watchdog_q   <= 8'd0;
      memTimeout_q <= 1'b0;
      cntStall_q   <= '0;
    end else begin
      state_q      <= state_d;
      watchdog_q   <= watchdog_d;
      memTimeout_q <= memTimeout_d;
      cntStall_q   <= cntStall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    watchdog_d   = watchdog_q;
    memTimeout_d = memTimeout_q;
    cntStall_d   = cntStall_q;
    case (state_q)
      RUN: begin
        if (memWait) begin
          state_d    = ESPERA_MEM;
          watchdog_d = 8'd1;
        end
      end
      ESPERA_MEM: begin
        if (pipe.mem_ack) begin
          state_d    = RUN;
          watchdog_d = 8'd0;
        end else if (watchdog_q == TIMEOUT_W) begin
          state_d      = RUN;
          watchdog_d   = 8'd0;
          memTimeout_d = 1'b1;
        end else begin
          watchdog_d = watchdog_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
    if (!pipe.pc_en && (cntStall_q != '1)) cntStall_d = cntStall_q + 1'b1;
  end

  // A frozen pipeline never flushes: a taken branch stays parked in EX until resume.
  always_comb begin
    pipe.pc_en          = 1'b1;
    pipe.if_id_en       = 1'b1;
    pipe.if_id_flush    = 1'b0;
    pipe.id_ex_en       = 1'b1;
    pipe.id_ex_flush    = 1'b0;
    pipe.ex_mem_en      = 1'b1;
    pipe.mem_wb_burbuja = 1'b0;
    if (rst_n) begin
      if (frozen) begin
        pipe.pc_en          = 1'b0;
        pipe.if_id_en       = 1'b0;
        pipe.id_ex_en       = 1'b0;
        pipe.ex_mem_en      = 1'b0;
        pipe.mem_wb_burbuja = 1'b1;
      end else if (pipe.ex_salto_tomado) begin
        pipe.if_id_flush = 1'b1;
        pipe.id_ex_flush = 1'b1;
      end else if (loadUse) begin
        pipe.pc_en       = 1'b0;
        pipe.if_id_en    = 1'b0;
        pipe.id_ex_flush = 1'b1;
      end
    end
  end

  assign pipe.mem_timeout = memTimeout_q;
  assign pipe.cnt_stall   = cntStall_q;

endmodule

// File: tb/tb_control_segmentacion.sv
// Directed and randomized check of control_segmentacion against a cycle-level reference
// model that tracks the memory wait as a plain cycle count.
module tb_control_segmentacion;

  localparam int TIMEOUT   = 4;
  localparam int R0_FIJO   = 1;
  localparam int ANCHO_CNT = 4;
  localparam int CNT_MAX   = (1 << ANCHO_CNT) - 1;

  logic clk = 1'b0;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  bit modelValid = 1'b0;
  bit mWaiting;
  int mWaitCycles;
  bit mTimeout;
  int mStalls;
  bit expPc;

  control_segmentacion_if #(.ANCHO_CNT(ANCHO_CNT)) pipe ();

  control_segmentacion #(
    .TIMEOUT  (TIMEOUT),
    .R0_FIJO  (R0_FIJO),
    .ANCHO_CNT(ANCHO_CNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pipe (pipe)
  );

  always #5 clk = ~clk;

  // A producer feeds a consumer only if it really writes a nonzero register of that name.
  function automatic bit feeds(input logic [3:0] src, input logic [3:0] dst, input logic wr);
    return (wr === 1'b1) && (src == dst) && (dst != 4'd0);
  endfunction

  function automatic logic [1:0] fwdModel(input logic [3:0] src);
    if (!rst_n) return 2'b00;
    if (feeds(src, pipe.mem_dir_wb, pipe.mem_reg_wr)) return 2'b01;
    if (feeds(src, pipe.wb_dir_wb, pipe.wb_reg_wr)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic compare(input string tag, input logic [15:0] got, input logic [15:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clearInputs();
    pipe.id_rs1 = 4'd0;  pipe.id_rs2 = 4'd0;  pipe.id_usa_rs1 = 1'b0; pipe.id_usa_rs2 = 1'b0;
    pipe.ex_rs1 = 4'd0;  pipe.ex_rs2 = 4'd0;  pipe.ex_dir_wb = 4'd0;  pipe.ex_reg_wr = 1'b0;
    pipe.ex_es_load = 1'b0; pipe.mem_dir_wb = 4'd0; pipe.mem_reg_wr = 1'b0;
    pipe.wb_dir_wb = 4'd0; pipe.wb_reg_wr = 1'b0; pipe.ex_salto_tomado = 1'b0;
    pipe.mem_req = 1'b0; pipe.mem_ack = 1'b0;
  endtask

  task automatic randomInputs();
    pipe.id_rs1 = 4'($urandom_range(0, 3));  pipe.id_rs2 = 4'($urandom_range(0, 3));
    pipe.id_usa_rs1 = 1'($urandom);          pipe.id_usa_rs2 = 1'($urandom);
    pipe.ex_rs1 = 4'($urandom_range(0, 3));  pipe.ex_rs2 = 4'($urandom_range(0, 3));
    pipe.ex_dir_wb = 4'($urandom_range(0, 3)); pipe.ex_reg_wr = 1'($urandom);
    pipe.ex_es_load = 1'($urandom);
    pipe.mem_dir_wb = 4'($urandom_range(0, 3)); pipe.mem_reg_wr = 1'($urandom);
    pipe.wb_dir_wb = 4'($urandom_range(0, 3));  pipe.wb_reg_wr = 1'($urandom);
    pipe.ex_salto_tomado = ($urandom_range(0, 7) == 0);
    pipe.mem_req = ($urandom_range(0, 2) == 0);
    pipe.mem_ack = 1'($urandom);
    rst_n = ($urandom_range(0, 59) != 0);
  endtask

  task automatic checkOutput(input string tag);
    logic memBusy, loadUse;
    logic [6:0] expCtl, gotCtl;
    // Memory is outstanding while a wait is open and unacknowledged, or a fresh request lacks its ack.
    memBusy = mWaiting ? !pipe.mem_ack : (pipe.mem_req && !pipe.mem_ack);
    loadUse = pipe.ex_es_load &&
              ((pipe.id_usa_rs1 && feeds(pipe.id_rs1, pipe.ex_dir_wb, pipe.ex_reg_wr)) ||
               (pipe.id_usa_rs2 && feeds(pipe.id_rs2, pipe.ex_dir_wb, pipe.ex_reg_wr)));
    // Order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_burbuja}
    if (!rst_n)                    expCtl = 7'b1101010;
    else if (memBusy)              expCtl = 7'b0000001;
    else if (pipe.ex_salto_tomado) expCtl = 7'b1111110;
    else if (loadUse)              expCtl = 7'b0001110;
    else                           expCtl = 7'b1101010;
    expPc  = expCtl[6];
    gotCtl = {pipe.pc_en, pipe.if_id_en, pipe.if_id_flush, pipe.id_ex_en, pipe.id_ex_flush,
              pipe.ex_mem_en, pipe.mem_wb_burbuja};
    compare({tag, ".ctl"}, 16'(gotCtl), 16'(expCtl));
    compare({tag, ".fwd_a"}, 16'(pipe.fwd_a), 16'(fwdModel(pipe.ex_rs1)));
    compare({tag, ".fwd_b"}, 16'(pipe.fwd_b), 16'(fwdModel(pipe.ex_rs2)));
    if (modelValid) begin
      compare({tag, ".mem_timeout"}, 16'(pipe.mem_timeout), 16'(mTimeout));
      compare({tag, ".cnt_stall"}, 16'(pipe.cnt_stall), 16'(mStalls));
    end
  endtask

  task automatic advanceModel();
    if (!rst_n) begin
      mWaiting = 1'b0; mWaitCycles = 0; mTimeout = 1'b0; mStalls = 0; modelValid = 1'b1;
    end else begin
      if (!mWaiting) begin
        if (pipe.mem_req && !pipe.mem_ack) begin
          mWaiting = 1'b1; mWaitCycles = 1;
        end
      end else if (pipe.mem_ack) begin
        mWaiting = 1'b0;
      end else if (mWaitCycles == TIMEOUT) begin
        mWaiting = 1'b0; mTimeout = 1'b1;
      end else begin
        mWaitCycles++;
      end
      if (!expPc && mStalls < CNT_MAX) mStalls++;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput(tag);
    @(posedge clk);
    advanceModel();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    pipe.ex_rs1 = 4'd5; pipe.mem_dir_wb = 4'd5; pipe.mem_reg_wr = 1'b1;
    pipe.mem_req = 1'b1;
    @(negedge clk);
    applyStimulus("reset0");
    applyStimulus("reset1");

    rst_n = 1'b1;
    clearInputs();
    applyStimulus("idle");

    pipe.ex_rs1 = 4'd5; pipe.ex_rs2 = 4'd5;
    pipe.mem_dir_wb = 4'd5; pipe.mem_reg_wr = 1'b1;
    pipe.wb_dir_wb = 4'd5;  pipe.wb_reg_wr = 1'b1;
    applyStimulus("fwd_mem_prio");
    pipe.mem_reg_wr = 1'b0;
    applyStimulus("fwd_wb");
    pipe.ex_rs1 = 4'd0; pipe.ex_rs2 = 4'd0; pipe.mem_dir_wb = 4'd0; pipe.wb_dir_wb = 4'd0;
    pipe.mem_reg_wr = 1'b1;
    applyStimulus("fwd_r0");

    clearInputs();
    pipe.ex_es_load = 1'b1; pipe.ex_dir_wb = 4'd3; pipe.ex_reg_wr = 1'b1;
    pipe.id_rs2 = 4'd3; pipe.id_usa_rs2 = 1'b1;
    applyStimulus("load_use");
    pipe.ex_es_load = 1'b0;
    applyStimulus("load_use_after");

    pipe.ex_es_load = 1'b1; pipe.ex_salto_tomado = 1'b1;
    applyStimulus("branch_over_lu");
    clearInputs();
    applyStimulus("branch_after");

    pipe.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("mem_wait");
    pipe.mem_ack = 1'b1;
    applyStimulus("mem_ack");
    clearInputs();
    applyStimulus("mem_after");

    pipe.mem_req = 1'b1; pipe.ex_salto_tomado = 1'b1;
    applyStimulus("branch_frozen0");
    applyStimulus("branch_frozen1");
    pipe.mem_ack = 1'b1;
    applyStimulus("branch_resume");
    clearInputs();

    pipe.mem_req = 1'b1;
    for (int i = 0; i <= TIMEOUT; i++) applyStimulus("timeout_wait");
    pipe.mem_req = 1'b0;
    applyStimulus("timeout_set");
    applyStimulus("timeout_sticky");

    pipe.mem_req = 1'b1;
    applyStimulus("midwait0");
    applyStimulus("midwait1");
    rst_n = 1'b0;
    applyStimulus("midwait_reset");
    rst_n = 1'b1;
    pipe.mem_req = 1'b0;
    applyStimulus("after_reset");

    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus("random");
    end

    rst_n = 1'b1;
    clearInputs();
    applyStimulus("final");

    $display("[TB] directed and random phases complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
